// File: rtl/ram_tp_be_pipe.sv
// ram_tp_be_pipe: 1W/1R RAM with per-lane write enables; RAM_TP_BE_BYPASS_EN selects write-through on collisions.
// Latency: read data 1 cycle after the read edge (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Backpressure: none; one write and one read accepted every cycle.
module ram_tp_be_pipe #(
    parameter  int ADR_WD  = 5,
    parameter  int DEPTH   = 32,
    parameter  int DAT_WD  = 64,
    parameter  int COL_WD  = 8,
    parameter  int OUT_REG = 0,
    localparam int BE_WD   = DAT_WD / COL_WD
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [BE_WD-1:0]  wr_ena_i,
    input  logic [ADR_WD-1:0] wr_adr_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    input  logic              rd_ena_i,
    input  logic [ADR_WD-1:0] rd_adr_i,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic              rd_val_o
);

    if (DAT_WD % COL_WD != 0) begin : g_chk_col
        $error("ram_tp_be_pipe: DAT_WD must be a multiple of COL_WD");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADR_WD)) begin : g_chk_depth
        $error("ram_tp_be_pipe: DEPTH must be in 1..2**ADR_WD");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_chk_outreg
        $error("ram_tp_be_pipe: OUT_REG must be 0 or 1");
    end

    localparam logic [ADR_WD:0] DEPTH_W = (ADR_WD + 1)'(DEPTH);

    // Storage is deliberately not reset: contents survive rstn.
    logic [DAT_WD-1:0] mem_q [DEPTH];

    logic              wr_in_rng;
    logic              rd_in_rng;
    logic [DAT_WD-1:0] rd_word;

    assign wr_in_rng = ({1'b0, wr_adr_i} < DEPTH_W);
    assign rd_in_rng = ({1'b0, rd_adr_i} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (wr_in_rng) begin
            for (int l = 0; l < BE_WD; l++) begin
                if (wr_ena_i[l]) begin
                    mem_q[wr_adr_i][l*COL_WD +: COL_WD] <= wr_dat_i[l*COL_WD +: COL_WD];
                end
            end
        end
    end

    // Array read sees pre-edge contents; forwarding merges the in-flight write lanes.
    always_comb begin
        rd_word = '0;
        if (rd_in_rng) begin
            rd_word = mem_q[rd_adr_i];
`ifdef RAM_TP_BE_BYPASS_EN
            if (wr_in_rng && (wr_adr_i == rd_adr_i)) begin
                for (int l = 0; l < BE_WD; l++) begin
                    if (wr_ena_i[l]) begin
                        rd_word[l*COL_WD +: COL_WD] = wr_dat_i[l*COL_WD +: COL_WD];
                    end
                end
            end
`endif
        end
    end

    logic              s1_val_q, s1_val_d;
    logic [DAT_WD-1:0] s1_dat_q, s1_dat_d;

    always_comb begin
        s1_val_d = rd_ena_i;
        s1_dat_d = rd_ena_i ? rd_word : s1_dat_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_val_q <= 1'b0;
            s1_dat_q <= '0;
        end else begin
            s1_val_q <= s1_val_d;
            s1_dat_q <= s1_dat_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              s2_val_q, s2_val_d;
        logic [DAT_WD-1:0] s2_dat_q, s2_dat_d;

        always_comb begin
            s2_val_d = s1_val_q;
            s2_dat_d = s1_val_q ? s1_dat_q : s2_dat_q;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s2_val_q <= 1'b0;
                s2_dat_q <= '0;
            end else begin
                s2_val_q <= s2_val_d;
                s2_dat_q <= s2_dat_d;
            end
        end

        assign rd_val_o = s2_val_q;
        assign rd_dat_o = s2_dat_q;
    end else begin : g_no_out_reg
        assign rd_val_o = s1_val_q;
        assign rd_dat_o = s1_dat_q;
    end

endmodule

// File: tb/tb_ram_tp_be_pipe.sv
// Bench: two instances (OUT_REG=0 and 1) share stimulus; a word-level memory model feeds per-port scoreboards.
module tb_ram_tp_be_pipe;
    localparam int ADR_WD = 6;
    localparam int DEPTH  = 40;
    localparam int DAT_WD = 64;
    localparam int COL_WD = 8;
    localparam int BE_WD  = DAT_WD / COL_WD;

    typedef struct {
        logic [DAT_WD-1:0] dat;
        int unsigned       due;
    } exp_t;

    logic              clk;
    logic              rstn;
    logic [BE_WD-1:0]  wr_ena_i;
    logic [ADR_WD-1:0] wr_adr_i;
    logic [DAT_WD-1:0] wr_dat_i;
    logic              rd_ena_i;
    logic [ADR_WD-1:0] rd_adr_i;
    logic [DAT_WD-1:0] rd_dat0, rd_dat1;
    logic              rd_val0, rd_val1;

    int unsigned       cyc;
    int                n_chk;
    int                n_fail;
    exp_t              q0[$];
    exp_t              q1[$];
    logic [DAT_WD-1:0] last0, last1;
    logic [DAT_WD-1:0] mdl [DEPTH];

    ram_tp_be_pipe #(.ADR_WD(ADR_WD), .DEPTH(DEPTH), .DAT_WD(DAT_WD), .COL_WD(COL_WD), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .wr_ena_i(wr_ena_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
        .rd_ena_i(rd_ena_i), .rd_adr_i(rd_adr_i), .rd_dat_o(rd_dat0), .rd_val_o(rd_val0));

    ram_tp_be_pipe #(.ADR_WD(ADR_WD), .DEPTH(DEPTH), .DAT_WD(DAT_WD), .COL_WD(COL_WD), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .wr_ena_i(wr_ena_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
        .rd_ena_i(rd_ena_i), .rd_adr_i(rd_adr_i), .rd_dat_o(rd_dat1), .rd_val_o(rd_val1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [DAT_WD-1:0] act, input logic [DAT_WD-1:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [DAT_WD-1:0] merge(input logic [DAT_WD-1:0] old, input logic [DAT_WD-1:0] nw,
                                                input logic [BE_WD-1:0] en);
        logic [DAT_WD-1:0] r;
        r = old;
        for (int l = 0; l < BE_WD; l++)
            if (en[l]) r[l*COL_WD +: COL_WD] = nw[l*COL_WD +: COL_WD];
        return r;
    endfunction

    // Monitor for one port: reset zeros, in-order pops with latency check, hold between pulses.
    task automatic mon_port(input int k, input logic v, input logic [DAT_WD-1:0] d);
        exp_t e;
        int   qs;
        if (!rstn) begin
            chk(v == 1'b0, $sformatf("p%0d_rst_val", k), {63'd0, v}, '0);
            chk(d == '0, $sformatf("p%0d_rst_dat", k), d, '0);
            return;
        end
        qs = (k == 0) ? q0.size() : q1.size();
        if (v) begin
            chk(qs != 0, $sformatf("p%0d_val_without_read", k), {63'd0, v}, '0);
            if (qs == 0) return;
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk(d === e.dat, $sformatf("p%0d_rd_dat", k), d, e.dat);
            chk(cyc == e.due, $sformatf("p%0d_latency", k), DAT_WD'(cyc), DAT_WD'(e.due));
            if (k == 0) last0 = e.dat;
            else        last1 = e.dat;
        end else begin
            chk(d === ((k == 0) ? last0 : last1), $sformatf("p%0d_hold", k), d, (k == 0) ? last0 : last1);
            if (qs != 0) begin
                e = (k == 0) ? q0[0] : q1[0];
                chk(cyc < e.due, $sformatf("p%0d_missing_val", k), DAT_WD'(cyc), DAT_WD'(e.due));
            end
        end
    endtask

    always @(negedge clk) begin
        mon_port(0, rd_val0, rd_dat0);
        mon_port(1, rd_val1, rd_dat1);
    end

    // One clock of stimulus; the model computes the read result from spec rules before applying the write.
    task automatic step(input logic [BE_WD-1:0] we, input int wa, input logic [DAT_WD-1:0] wd,
                        input logic re, input int ra);
        logic [DAT_WD-1:0] r;
        wr_ena_i = we;
        wr_adr_i = ADR_WD'(wa);
        wr_dat_i = wd;
        rd_ena_i = re;
        rd_adr_i = ADR_WD'(ra);
        if (re && rstn) begin
            r = (ra < DEPTH) ? mdl[ra] : '0;
`ifdef RAM_TP_BE_BYPASS_EN
            if (ra == wa && wa < DEPTH) r = merge(r, wd, we);
`endif
            q0.push_back('{r, cyc + 1});
            q1.push_back('{r, cyc + 2});
        end
        if (wa < DEPTH) mdl[wa] = merge(mdl[wa], wd, we);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 0, '0, 1'b0, 0);
    endtask

    task automatic do_reset(input int cycles, input int radr);
        rstn = 1'b0;
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        wr_ena_i = '0;
        rd_ena_i = 1'b1;
        rd_adr_i = ADR_WD'(radr);
        repeat (cycles) @(posedge clk);
        #1;
        rd_ena_i = 1'b0;
        rstn = 1'b1;
    endtask

    initial begin
        int wa, ra;
        logic [BE_WD-1:0] we;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        last0 = '0;
        last1 = '0;
        rstn = 1'b1;
        wr_ena_i = '0;
        wr_adr_i = '0;
        wr_dat_i = '0;
        rd_ena_i = 1'b0;
        rd_adr_i = '0;
        #2;
        do_reset(3, 0);

        for (int a = 0; a < DEPTH; a++) step('1, a, {$urandom(), $urandom()}, 1'b0, 0);
        step('1, 3, 64'h1122334455667788, 1'b0, 0);
        do_reset(3, 3);
        step('0, 0, '0, 1'b1, 3);
        idle(3);

        step('1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        step(8'h0F, 5, 64'h0, 1'b0, 0);
        step('0, 0, '0, 1'b1, 5);
        idle(3);

        for (int a = 0; a < DEPTH; a++) step('1, a, DAT_WD'(a), 1'b0, 0);
        for (int a = 0; a < DEPTH; a++) step('0, 0, '0, 1'b1, a);
        idle(4);

        step('1, 7, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 0);
        step(8'hF0, 7, 64'h5555_5555_5555_5555, 1'b1, 7);
        step('0, 0, '0, 1'b1, 7);
        idle(3);

        step('1, 45, 64'h1234, 1'b0, 0);
        step('0, 0, '0, 1'b1, 45);
        step('0, 0, '0, 1'b1, 5);
        idle(3);

        step('0, 0, '0, 1'b1, 3);
        do_reset(2, 9);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            we = BE_WD'($urandom());
            if ($urandom_range(0, 3) == 0) we = '0;
            wa = $urandom_range(0, (1 << ADR_WD) - 1);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, (1 << ADR_WD) - 1);
            step(we, wa, {$urandom(), $urandom()}, ($urandom_range(0, 3) != 0), ra);
            if (i == 1500) begin
                step('0, 0, '0, 1'b1, 11);
                do_reset(2, 4);
            end
        end
        idle(4);
        chk(q0.size() == 0, "p0_drained", DAT_WD'(q0.size()), '0);
        chk(q1.size() == 0, "p1_drained", DAT_WD'(q1.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
